dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_pkg.sv | 22 ++
 rtl/dmem_array.sv | 33 +++
 rtl/dmem_responder.sv | 108 ++++++++++
 tb/tb_dmem_responder.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared constants for the dmem responder: state encoding, widths, default geometry.
package dmem_pkg;

  localparam int DEF_ADDR_BITS   = 8;
  localparam int DEF_WAIT_CYCLES = 1;
  localparam int ADDR_W          = 16;
  localparam int DATA_W          = 16;
  localparam int WCNT_W          = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_ACK    = 2'd3
  } state_e;

  // True when any address bit above the array index is set.
  function automatic logic addr_oor(input logic [ADDR_W-1:0] a, input int bits);
    return (a >> bits) != '0;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous RAM; write and registered read both happen on an enabled edge.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int ADDR_BITS = DEF_ADDR_BITS
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 we,
  input  logic                 clr,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [DATA_W-1:0]    wdata,
  output logic [DATA_W-1:0]    rdata
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage is deliberately not reset so it maps onto a plain RAM macro.
  always_ff @(posedge clock) begin
    if (en && we && !clr) mem[addr] <= wdata;
  end

  // Read register holds its value across writes; a rejected access zeroes it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)          rdata <= '0;
    else if (en && clr)  rdata <= '0;
    else if (en && !we)  rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_responder.sv
// Four-phase req/ack responder in front of a wait-stated 16-bit RAM.
// Define DMEM_RANGE_ERR_EN to add an err output that rejects addresses beyond the array depth.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_BITS   = DEF_ADDR_BITS,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ack,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [1:0]        o_state
`ifdef DMEM_RANGE_ERR_EN
  ,
  output logic              err
`endif
);

  localparam logic [WCNT_W-1:0] WAIT_LD = WCNT_W'(WAIT_CYCLES);

  typedef struct packed {
    logic                 we;
    logic [ADDR_BITS-1:0] addr;
    logic [DATA_W-1:0]    wdata;
    logic                 oor;
  } lat_t;

  state_e            state;
  lat_t              lat;
  logic [WCNT_W-1:0] wcnt;
  logic              oor_in;

`ifdef DMEM_RANGE_ERR_EN
  assign oor_in = addr_oor(addr, ADDR_BITS);
`else
  // Upper address bits simply alias onto the array.
  logic unused_addr;
  assign unused_addr = ^addr;
  assign oor_in      = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      ack   <= 1'b0;
      busy  <= 1'b0;
      wcnt  <= '0;
      lat   <= '0;
`ifdef DMEM_RANGE_ERR_EN
      err   <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (req) begin
            lat   <= '{we: we, addr: addr[ADDR_BITS-1:0], wdata: wdata, oor: oor_in};
            wcnt  <= WAIT_LD;
            busy  <= 1'b1;
            state <= (WAIT_LD == '0) ? ST_ACCESS : ST_WAIT;
          end
        end
        ST_WAIT: begin
          wcnt <= wcnt - 1'b1;
          if (wcnt <= WCNT_W'(1)) state <= ST_ACCESS;
        end
        ST_ACCESS: begin
          state <= ST_ACK;
          ack   <= 1'b1;
`ifdef DMEM_RANGE_ERR_EN
          err   <= lat.oor;
`endif
        end
        ST_ACK: begin
          // Only a sampled low req releases ACK, so a held req cannot chain a second access.
          if (!req) begin
            state <= ST_IDLE;
            ack   <= 1'b0;
            busy  <= 1'b0;
`ifdef DMEM_RANGE_ERR_EN
            err   <= 1'b0;
`endif
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign o_state = state;

  dmem_array #(.ADDR_BITS(ADDR_BITS)) u_array (
    .clock (clock),
    .reset (reset),
    .en    (state == ST_ACCESS),
    .we    (lat.we),
    .clr   (lat.oor),
    .addr  (lat.addr),
    .wdata (lat.wdata),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder against a word-array reference model.
module tb_dmem_responder;

  localparam int AB = 8;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic req = 1'b0, req_x = 1'b0, we = 1'b0;
  logic [15:0] addr = '0, wdata = '0;
  logic ack, busy, ack0, busy0, ack3, busy3;
  logic [15:0] rdata, rdata0, rdata3;
  logic [1:0] o_state, st0, st3;
`ifdef DMEM_RANGE_ERR_EN
  logic err, err0, err3;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [15:0] ref_mem [256];
  logic [15:0] exp_rdata;
  logic        exp_err;

  always #5 clock = ~clock;

  dmem_responder #(.ADDR_BITS(AB), .WAIT_CYCLES(1)) u_dut (
    .clock(clock), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack), .rdata(rdata), .busy(busy), .o_state(o_state)
`ifdef DMEM_RANGE_ERR_EN
    , .err(err)
`endif
  );

  dmem_responder #(.ADDR_BITS(AB), .WAIT_CYCLES(0)) u_dut0 (
    .clock(clock), .reset(reset), .req(req_x), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack0), .rdata(rdata0), .busy(busy0), .o_state(st0)
`ifdef DMEM_RANGE_ERR_EN
    , .err(err0)
`endif
  );

  dmem_responder #(.ADDR_BITS(AB), .WAIT_CYCLES(3)) u_dut3 (
    .clock(clock), .reset(reset), .req(req_x), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack3), .rdata(rdata3), .busy(busy3), .o_state(st3)
`ifdef DMEM_RANGE_ERR_EN
    , .err(err3)
`endif
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference: 256 words, upper address bits alias (or are rejected with err).
  function automatic void model_txn(input bit w, input logic [15:0] a, input logic [15:0] d);
    int idx;
    idx = int'(a % 16'd256);
    exp_err = 1'b0;
`ifdef DMEM_RANGE_ERR_EN
    if (a >= 16'd256) begin
      exp_err   = 1'b1;
      exp_rdata = 16'h0000;
      return;
    end
`endif
    if (w) ref_mem[idx] = d;
    else   exp_rdata = ref_mem[idx];
  endfunction

  task automatic run_txn(input bit w, input logic [15:0] a, input logic [15:0] d,
                         output int lat, output logic [15:0] rd, output logic e);
    req = 1'b1; we = w; addr = a; wdata = d;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (ack === 1'b1) begin lat = n; break; end
    end
    rd = rdata;
`ifdef DMEM_RANGE_ERR_EN
    e = err;
`else
    e = 1'b0;
`endif
    req = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    #2;
    total_cnt++; if (ack !== 1'b0) $display("FAIL rst_ack: got %b want 0", ack); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (o_state !== 2'd0) $display("FAIL rst_state: got %0d want 0", o_state); else pass_cnt++;
    total_cnt++; if (rdata !== 16'h0000) $display("FAIL rst_rdata: got %h want 0000", rdata); else pass_cnt++;
    total_cnt++; if ({busy0, busy3, st0, st3} !== 6'd0) $display("FAIL rst_other: got %b want 0", {busy0, busy3, st0, st3}); else pass_cnt++;
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_latency();
    int l1, l0, l3;
    l1 = -1; l0 = -1; l3 = -1;
    req = 1'b1; req_x = 1'b1; we = 1'b0; addr = 16'h0000; wdata = 16'h0;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (ack === 1'b1 && l1 < 0) l1 = n;
      if (ack0 === 1'b1 && l0 < 0) l0 = n;
      if (ack3 === 1'b1 && l3 < 0) l3 = n;
      if (l1 > 0 && l0 > 0 && l3 > 0) break;
    end
    model_txn(1'b0, 16'h0000, 16'h0);
    total_cnt++; if (l1 != 3) $display("FAIL lat_w1: got %0d want 3", l1); else pass_cnt++;
    total_cnt++; if (l0 != 2) $display("FAIL lat_w0: got %0d want 2", l0); else pass_cnt++;
    total_cnt++; if (l3 != 5) $display("FAIL lat_w3: got %0d want 5", l3); else pass_cnt++;
    total_cnt++; if (rdata !== exp_rdata) $display("FAIL lat_rd_w1: got %h want %h", rdata, exp_rdata); else pass_cnt++;
    total_cnt++; if ({rdata0, rdata3} !== {exp_rdata, exp_rdata}) $display("FAIL lat_rd_w03: got %h %h want %h", rdata0, rdata3, exp_rdata); else pass_cnt++;
    req = 1'b0; req_x = 1'b0;
    tick();
  endtask

  task automatic test_write_read();
    int lat; logic [15:0] rd; logic e;
    run_txn(1'b1, 16'h0005, 16'hBEEF, lat, rd, e);
    model_txn(1'b1, 16'h0005, 16'hBEEF);
    total_cnt++; if (lat != 3) $display("FAIL wr_lat: got %0d want 3", lat); else pass_cnt++;
    total_cnt++; if (rd !== exp_rdata) $display("FAIL wr_rdata_kept: got %h want %h", rd, exp_rdata); else pass_cnt++;
    run_txn(1'b0, 16'h0005, 16'h0000, lat, rd, e);
    model_txn(1'b0, 16'h0005, 16'h0000);
    total_cnt++; if (lat != 3) $display("FAIL rd_lat: got %0d want 3", lat); else pass_cnt++;
    total_cnt++; if (rd !== 16'hBEEF) $display("FAIL rd_beef: got %h want beef", rd); else pass_cnt++;
  endtask

  task automatic test_alias();
    int lat; logic [15:0] rd; logic e;
    run_txn(1'b1, 16'h0107, 16'h1234, lat, rd, e);
    model_txn(1'b1, 16'h0107, 16'h1234);
`ifdef DMEM_RANGE_ERR_EN
    total_cnt++; if (e !== 1'b1) $display("FAIL alias_err: got %b want 1", e); else pass_cnt++;
`endif
    total_cnt++; if (rd !== exp_rdata) $display("FAIL alias_wr_rd: got %h want %h", rd, exp_rdata); else pass_cnt++;
    run_txn(1'b0, 16'h0007, 16'h0000, lat, rd, e);
    model_txn(1'b0, 16'h0007, 16'h0000);
    total_cnt++; if (rd !== exp_rdata) $display("FAIL alias_rd: got %h want %h", rd, exp_rdata); else pass_cnt++;
  endtask

  task automatic test_handshake();
    int lat;
    req = 1'b1; we = 1'b0; addr = 16'h0005; wdata = 16'h0;
    model_txn(1'b0, 16'h0005, 16'h0);
    for (int i = 1; i <= 10; i++) begin
      tick();
      total_cnt++;
      if (ack !== 1'(i >= 3)) $display("FAIL hold_ack_c%0d: got %b want %b", i, ack, 1'(i >= 3)); else pass_cnt++;
    end
    total_cnt++; if (o_state !== 2'd3) $display("FAIL hold_state: got %0d want 3", o_state); else pass_cnt++;
    total_cnt++; if (rdata !== exp_rdata) $display("FAIL hold_rdata: got %h want %h", rdata, exp_rdata); else pass_cnt++;
    req = 1'b0;
    tick();
    total_cnt++; if ({ack, o_state} !== 3'b0_00) $display("FAIL hold_exit: got ack=%b st=%0d want 0/0", ack, o_state); else pass_cnt++;
    tick(); tick();
    total_cnt++; if (busy !== 1'b0) $display("FAIL hold_no_second: got busy=%b want 0", busy); else pass_cnt++;
    // Single-cycle pulse on req
    req = 1'b1; addr = 16'h0007;
    tick();
    req = 1'b0;
    lat = -1;
    for (int n = 2; n <= 40; n++) begin
      tick();
      if (ack === 1'b1) begin lat = n; break; end
    end
    model_txn(1'b0, 16'h0007, 16'h0);
    total_cnt++; if (lat != 3) $display("FAIL pulse_lat: got %0d want 3", lat); else pass_cnt++;
    total_cnt++; if (rdata !== exp_rdata) $display("FAIL pulse_rd: got %h want %h", rdata, exp_rdata); else pass_cnt++;
    tick();
    total_cnt++; if (ack !== 1'b0) $display("FAIL pulse_ack_len: got %b want 0", ack); else pass_cnt++;
  endtask

  task automatic test_disturb();
    int lat; logic [15:0] rd; logic e;
    req = 1'b1; we = 1'b1; addr = 16'h0021; wdata = 16'h1111;
    tick();
    addr = 16'h0022; wdata = 16'h2222; we = 1'b0;
    lat = -1;
    for (int n = 2; n <= 40; n++) begin
      tick();
      if (ack === 1'b1) begin lat = n; break; end
    end
    model_txn(1'b1, 16'h0021, 16'h1111);
    total_cnt++; if (lat != 3) $display("FAIL dist_lat: got %0d want 3", lat); else pass_cnt++;
    total_cnt++; if (rdata !== exp_rdata) $display("FAIL dist_rd_kept: got %h want %h", rdata, exp_rdata); else pass_cnt++;
    req = 1'b0;
    tick();
    run_txn(1'b0, 16'h0021, 16'h0, lat, rd, e);
    model_txn(1'b0, 16'h0021, 16'h0);
    total_cnt++; if (rd !== 16'h1111) $display("FAIL dist_addr21: got %h want 1111", rd); else pass_cnt++;
    run_txn(1'b0, 16'h0022, 16'h0, lat, rd, e);
    model_txn(1'b0, 16'h0022, 16'h0);
    total_cnt++; if (rd !== exp_rdata) $display("FAIL dist_addr22: got %h want %h", rd, exp_rdata); else pass_cnt++;
  endtask

  task automatic test_reset_wait();
    int lat; logic [15:0] rd; logic e;
    run_txn(1'b1, 16'h0009, 16'h5555, lat, rd, e);
    model_txn(1'b1, 16'h0009, 16'h5555);
    req = 1'b1; we = 1'b1; addr = 16'h0009; wdata = 16'hAAAA;
    tick();
    total_cnt++; if (o_state !== 2'd1) $display("FAIL rw_in_wait: got %0d want 1", o_state); else pass_cnt++;
    #2 reset = 1'b0;
    #1;
    exp_rdata = 16'h0000;
    total_cnt++; if (busy !== 1'b0) $display("FAIL rw_busy: got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (o_state !== 2'd0) $display("FAIL rw_state: got %0d want 0", o_state); else pass_cnt++;
    total_cnt++; if (rdata !== exp_rdata) $display("FAIL rw_rdata: got %h want %h", rdata, exp_rdata); else pass_cnt++;
    req = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick(); tick();
    total_cnt++; if (ack !== 1'b0) $display("FAIL rw_no_ack: got %b want 0", ack); else pass_cnt++;
    run_txn(1'b0, 16'h0009, 16'h0, lat, rd, e);
    model_txn(1'b0, 16'h0009, 16'h0);
    total_cnt++; if (rd !== 16'h5555) $display("FAIL rw_old_val: got %h want 5555", rd); else pass_cnt++;
  endtask

  task automatic test_random();
    int lat; logic [15:0] rd, a, d; logic e; bit w;
    for (int i = 0; i < 30; i++) begin
      w = 1'($urandom_range(0, 1));
      a = 16'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) a[15:8] = 8'($urandom_range(1, 255));
      d = 16'($urandom);
      for (int g = $urandom_range(0, 2); g > 0; g--) tick();
      run_txn(w, a, d, lat, rd, e);
      model_txn(w, a, d);
      total_cnt++; if (lat != 3) $display("FAIL rnd%0d_lat: got %0d want 3", i, lat); else pass_cnt++;
      total_cnt++; if (rd !== exp_rdata) $display("FAIL rnd%0d_rd a=%h w=%b: got %h want %h", i, a, w, rd, exp_rdata); else pass_cnt++;
`ifdef DMEM_RANGE_ERR_EN
      total_cnt++; if (e !== exp_err) $display("FAIL rnd%0d_err: got %b want %b", i, e, exp_err); else pass_cnt++;
`endif
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = 16'h0000;
    exp_rdata = 16'h0000;
    exp_err   = 1'b0;
    test_reset();
    test_latency();
    test_write_read();
    test_alias();
    test_handshake();
    test_disturb();
    test_reset_wait();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
